// File: rtl/fir_axis_stereo_wrapper_if.sv
// AXI4-Stream and AXI4-Lite signal bundles for the stereo FIR wrapper.
// The stream carries {L[31:16], R[15:0]}. The lite bus is the control/coefficient port.
interface fir_axis_if #(parameter int DW = 32);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

interface fir_axil_if #(parameter int AW = 10, parameter int DW = 32);
  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
                  input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
  modport slave  (input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
                  output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
endinterface

// File: rtl/fir_axis_stereo_wrapper.sv
// Stereo 16-bit FIR with AXI4-Stream audio path and AXI4-Lite control/coefficient registers.
// Each channel has one MAC that processes one tap per cycle. Both channels use the same coefficients.
module fir_axis_stereo_wrapper #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH         = 32,
  parameter int FIR_NTAPS          = 16
) (
  input  logic       aclk,
  input  logic       aresetn,
  fir_axis_if.slave  s_axis,
  fir_axis_if.master m_axis,
  fir_axil_if.slave  s_axi
);

  localparam int AW         = C_S_AXI_ADDR_WIDTH;
  localparam int WW         = AW - 2;
  localparam int CIW        = $clog2(FIR_NTAPS);
  localparam int TW         = $clog2(FIR_NTAPS + 1);
  localparam int ACCW       = 32 + $clog2(FIR_NTAPS);
  localparam int COEFF_BASE = 4;

  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(32767);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-32768);

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;

  // ---------------- AXI4-Lite register file ----------------
  logic [1:0]                    ctrl;
  logic signed [15:0]            coeff [FIR_NTAPS];
  logic                          aw_ready, b_valid, ar_ready, r_valid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_data, rd_val;
  logic [WW-1:0]                 wr_word, rd_word;
  logic                          wr_fire, ar_fire;
  logic                          unused_bits;

  assign wr_word = s_axi.awaddr[AW-1:2];
  assign rd_word = s_axi.araddr[AW-1:2];
  assign wr_fire = aw_ready && s_axi.awvalid && s_axi.wvalid;
  assign ar_fire = ar_ready && s_axi.arvalid;
  assign unused_bits = ^{s_axi.wstrb, s_axi.wdata[C_S_AXI_DATA_WIDTH-1:16],
                         s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  function automatic logic is_coeff(input logic [WW-1:0] w);
    return (int'(w) >= COEFF_BASE) && (int'(w) < COEFF_BASE + FIR_NTAPS);
  endfunction

  function automatic logic [CIW-1:0] coeff_idx(input logic [WW-1:0] w);
    return CIW'(int'(w) - COEFF_BASE);
  endfunction

  // NOTE: assign a default to every always_comb output first, so that no path infers a latch.
  always_comb begin
    rd_val = '0;
    if (rd_word == WW'(0))   rd_val[1:0]  = ctrl;
    else if (rd_word == WW'(1)) rd_val    = C_S_AXI_DATA_WIDTH'(FIR_NTAPS);
    else if (is_coeff(rd_word)) rd_val[15:0] = coeff[coeff_idx(rd_word)];
  end

  // NOTE: the coefficient array is built from resettable flops because software can read back its reset value of zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_ready <= 1'b0;
      b_valid  <= 1'b0;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      ctrl     <= '0;
      for (int i = 0; i < FIR_NTAPS; i++) coeff[i] <= '0;
    end else begin
      // awready/wready pulse once for each transfer and stay low while a response is pending.
      aw_ready <= s_axi.awvalid && s_axi.wvalid && !b_valid && !aw_ready;
      if (wr_fire) begin
        b_valid <= 1'b1;
        if (wr_word == WW'(0))      ctrl <= s_axi.wdata[1:0];
        else if (is_coeff(wr_word)) coeff[coeff_idx(wr_word)] <= s_axi.wdata[15:0];
      end else if (s_axi.bready) begin
        b_valid <= 1'b0;
      end

      ar_ready <= s_axi.arvalid && !r_valid && !ar_ready;
      if (ar_fire) begin
        r_valid <= 1'b1;
        r_data  <= rd_val;
      end else if (s_axi.rready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign s_axi.awready = aw_ready;
  assign s_axi.wready  = aw_ready;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.bvalid  = b_valid;
  assign s_axi.arready = ar_ready;
  assign s_axi.rdata   = r_data;
  assign s_axi.rresp   = 2'b00;
  assign s_axi.rvalid  = r_valid;

  // ---------------- Filter datapath and sequencer ----------------
  state_t                 state;
  logic                   s_ready, m_valid, m_last;
  logic [DATA_WIDTH-1:0]  m_data;
  logic signed [15:0]     x_l [FIR_NTAPS];
  logic signed [15:0]     x_r [FIR_NTAPS];
  logic signed [ACCW-1:0] acc_l, acc_r;
  logic [TW-1:0]          tap;
  logic [CIW-1:0]         tap_idx;
  logic signed [31:0]     prod_l, prod_r;

  assign tap_idx = tap[CIW-1:0];
  assign prod_l  = 32'(x_l[tap_idx]) * 32'(coeff[tap_idx]);
  assign prod_r  = 32'(x_r[tap_idx]) * 32'(coeff[tap_idx]);

  // The Q1.15 result uses a floor shift, then saturates to 16 bits.
  function automatic logic [15:0] sat16(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    s = a >>> 15;
    if (s > SAT_MAX) return 16'h7fff;
    if (s < SAT_MIN) return 16'h8000;
    return s[15:0];
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ST_IDLE;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
      acc_l   <= '0;
      acc_r   <= '0;
      tap     <= '0;
      for (int i = 0; i < FIR_NTAPS; i++) begin
        x_l[i] <= '0;
        x_r[i] <= '0;
      end
    end else if (ctrl[1]) begin
      // Any sample that is in flight is discarded while CLEAR stays high.
      state   <= ST_IDLE;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      for (int i = 0; i < FIR_NTAPS; i++) begin
        x_l[i] <= '0;
        x_r[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_ready && s_axis.tvalid) begin
            s_ready <= 1'b0;
            m_last  <= s_axis.tlast;
            if (ctrl[0]) begin
              x_l[0] <= s_axis.tdata[31:16];
              x_r[0] <= s_axis.tdata[15:0];
              for (int k = 1; k < FIR_NTAPS; k++) begin
                x_l[k] <= x_l[k-1];
                x_r[k] <= x_r[k-1];
              end
              acc_l <= '0;
              acc_r <= '0;
              tap   <= '0;
              state <= ST_MAC;
            end else begin
              m_data  <= s_axis.tdata;
              m_valid <= 1'b1;
              state   <= ST_OUT;
            end
          end else begin
            s_ready <= 1'b1;
          end
        end
        ST_MAC: begin
          // The tap counter runs up to FIR_NTAPS. Its final value is the cycle that scales and saturates the result.
          if (tap == TW'(FIR_NTAPS)) begin
            m_data  <= {sat16(acc_l), sat16(acc_r)};
            m_valid <= 1'b1;
            state   <= ST_OUT;
          end else begin
            acc_l <= acc_l + ACCW'(prod_l);
            acc_r <= acc_r + ACCW'(prod_r);
            tap   <= tap + TW'(1);
          end
        end
        ST_OUT: begin
          if (m_axis.tready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = m_data;
  assign m_axis.tlast  = m_last;

endmodule

// File: tb/tb_fir_axis_stereo_wrapper.sv
// Directed self-checking bench for fir_axis_stereo_wrapper. It covers register access, bypass,
// impulse response, a 2-tap average, saturation, backpressure and CLEAR in the middle of a MAC.
module tb_fir_axis_stereo_wrapper;
  localparam int N  = 16;
  localparam int AW = 10;
  localparam logic [AW-1:0] A_CTRL  = 10'h000;
  localparam logic [AW-1:0] A_NTAPS = 10'h004;
  localparam logic [AW-1:0] A_UNMAP = 10'h008;
  localparam logic [AW-1:0] A_COEFF = 10'h010;
  localparam int LIMIT = 100;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  fir_axis_if #(.DW(32))         s_axis ();
  fir_axis_if #(.DW(32))         m_axis ();
  fir_axil_if #(.AW(AW), .DW(32)) s_axi ();

  fir_axis_stereo_wrapper #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AW),
    .DATA_WIDTH(32),
    .FIR_NTAPS(N)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .s_axis (s_axis),
    .m_axis (m_axis),
    .s_axi  (s_axi)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] coeff_addr(input int i);
    return A_COEFF + AW'(4 * i);
  endfunction

  task automatic axil_write(input logic [AW-1:0] addr, input logic [31:0] data, input int hold);
    int n;
    s_axi.awaddr  = addr;
    s_axi.wdata   = data;
    s_axi.wstrb   = 4'hf;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    n = 0;
    while (!s_axi.awready && n < LIMIT) begin @(posedge aclk); #1; n++; end
    check("aw_wait", 32'(n < LIMIT), 32'd1);
    check("wready_with_awready", 32'(s_axi.wready), 32'd1);
    @(posedge aclk); #1;
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    n = 0;
    while (!s_axi.bvalid && n < LIMIT) begin @(posedge aclk); #1; n++; end
    check("b_wait", 32'(n < LIMIT), 32'd1);
    check("bresp", 32'(s_axi.bresp), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge aclk); #1;
      check("bvalid_hold", 32'(s_axi.bvalid), 32'd1);
    end
    s_axi.bready = 1'b1;
    @(posedge aclk); #1;
    s_axi.bready = 1'b0;
    if (hold > 0) check("bvalid_drop", 32'(s_axi.bvalid), 32'd0);
  endtask

  task automatic axil_read(input logic [AW-1:0] addr, output logic [31:0] data, input int hold);
    int n;
    s_axi.araddr  = addr;
    s_axi.arvalid = 1'b1;
    n = 0;
    while (!s_axi.arready && n < LIMIT) begin @(posedge aclk); #1; n++; end
    check("ar_wait", 32'(n < LIMIT), 32'd1);
    @(posedge aclk); #1;
    s_axi.arvalid = 1'b0;
    n = 0;
    while (!s_axi.rvalid && n < LIMIT) begin @(posedge aclk); #1; n++; end
    check("r_wait", 32'(n < LIMIT), 32'd1);
    check("rresp", 32'(s_axi.rresp), 32'd0);
    data = s_axi.rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge aclk); #1;
      check("rvalid_hold", 32'(s_axi.rvalid), 32'd1);
      check("rdata_hold", s_axi.rdata, data);
    end
    s_axi.rready = 1'b1;
    @(posedge aclk); #1;
    s_axi.rready = 1'b0;
    if (hold > 0) check("rvalid_drop", 32'(s_axi.rvalid), 32'd0);
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int n;
    s_axis.tdata  = d;
    s_axis.tlast  = last;
    s_axis.tvalid = 1'b1;
    n = 0;
    while (!s_axis.tready && n < LIMIT) begin @(posedge aclk); #1; n++; end
    check("s_tready_wait", 32'(n < LIMIT), 32'd1);
    @(posedge aclk); #1;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  // The latency result counts clock edges from the input handshake edge until tvalid is seen.
  task automatic recv(output logic [31:0] d, output logic last, output int lat);
    int n;
    m_axis.tready = 1'b1;
    n = 0;
    while (!m_axis.tvalid && n < LIMIT) begin @(posedge aclk); #1; n++; end
    check("m_tvalid_wait", 32'(n < LIMIT), 32'd1);
    d    = m_axis.tdata;
    last = m_axis.tlast;
    lat  = n;
    @(posedge aclk); #1;
    m_axis.tready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        l;
    int          lat;

    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b0;
    s_axi.awaddr  = '0;
    s_axi.awvalid = 1'b0;
    s_axi.wdata   = '0;
    s_axi.wstrb   = '0;
    s_axi.wvalid  = 1'b0;
    s_axi.bready  = 1'b0;
    s_axi.araddr  = '0;
    s_axi.arvalid = 1'b0;
    s_axi.rready  = 1'b0;

    // Outputs while reset is held.
    #1;
    check("rst_s_tready", 32'(s_axis.tready), 32'd0);
    check("rst_m_tvalid", 32'(m_axis.tvalid), 32'd0);
    check("rst_m_tdata",  m_axis.tdata, 32'd0);
    check("rst_awready",  32'(s_axi.awready), 32'd0);
    check("rst_bvalid",   32'(s_axi.bvalid), 32'd0);
    check("rst_rvalid",   32'(s_axi.rvalid), 32'd0);
    check("rst_rdata",    s_axi.rdata, 32'd0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    check("idle_s_tready", 32'(s_axis.tready), 32'd1);

    // Register reset values and read protocol.
    axil_read(A_CTRL, d, 3);         check("ctrl_reset", d, 32'd0);
    axil_read(coeff_addr(0), d, 0);  check("coeff0_reset", d, 32'd0);
    axil_read(A_NTAPS, d, 0);        check("ntaps", d, 32'd16);
    axil_read(A_UNMAP, d, 0);        check("unmapped_read", d, 32'd0);

    // Bypass with ENABLE=0. The sample passes unchanged and tlast is carried through.
    axil_write(A_CTRL, 32'd0, 3);
    send(32'h04D2_FFFB, 1'b1);
    recv(d, l, lat);
    check("bypass_data", d, 32'h04D2_FFFB);
    check("bypass_tlast", 32'(l), 32'd1);
    check("bypass_latency", 32'(lat), 32'd0);

    // Impulse test: COEFF[0]=32767 applied to {10000,-10000}.
    axil_write(A_CTRL, 32'd2, 0);
    axil_write(A_CTRL, 32'd0, 0);
    axil_write(coeff_addr(0), 32'h0000_7FFF, 0);
    axil_write(A_CTRL, 32'd1, 0);
    send(32'h2710_D8F0, 1'b0);
    recv(d, l, lat);
    check("impulse_data", d, 32'h270F_D8F0);
    check("impulse_tlast", 32'(l), 32'd0);
    check("impulse_latency", 32'(lat), 32'(N + 1));
    for (int i = 0; i < 10; i++) begin
      send(32'h0, (i == 9));
      recv(d, l, lat);
      check($sformatf("impulse_zero_%0d", i), d, 32'h0);
      check($sformatf("impulse_tlast_%0d", i), 32'(l), 32'((i == 9) ? 1 : 0));
    end

    // 2-tap average using 0.5 * x[0] + 0.5 * x[1].
    axil_write(A_CTRL, 32'd2, 0);
    axil_write(coeff_addr(0), 32'h0000_4000, 0);
    axil_write(coeff_addr(1), 32'h0000_4000, 0);
    axil_write(A_CTRL, 32'd1, 0);
    send(32'h2710_2710, 1'b0); recv(d, l, lat); check("avg_0", d, 32'h1388_1388);
    send(32'h0, 1'b0);         recv(d, l, lat); check("avg_1", d, 32'h1388_1388);
    send(32'h0, 1'b0);         recv(d, l, lat); check("avg_2", d, 32'h0);

    // Saturation: all coefficients set to 32767, input at full scale.
    axil_write(A_CTRL, 32'd2, 0);
    for (int i = 0; i < N; i++) axil_write(coeff_addr(i), 32'h0000_7FFF, 0);
    axil_write(A_CTRL, 32'd1, 0);
    for (int i = 0; i < N; i++) begin
      send(32'h7FFF_8000, (i == N - 1));
      recv(d, l, lat);
      check($sformatf("sat_%0d", i), d, (i == 0) ? 32'h7FFE_8001 : 32'h7FFF_8000);
    end
    check("sat_tlast", 32'(l), 32'd1);

    // Register boundaries: read back a coefficient, the last coefficient, the RO NTAPS register, and an out-of-range address.
    axil_read(coeff_addr(5), d, 0);              check("coeff5_read", d, 32'h0000_7FFF);
    axil_write(coeff_addr(N - 1), 32'hABCD_8000, 0);
    axil_read(coeff_addr(N - 1), d, 0);          check("coeff_last_read", d, 32'h0000_8000);
    axil_write(A_NTAPS, 32'd5, 0);
    axil_read(A_NTAPS, d, 0);                    check("ntaps_ro", d, 32'd16);
    axil_write(coeff_addr(N), 32'h0000_1234, 0);
    axil_read(coeff_addr(N), d, 0);              check("coeff_oor_read", d, 32'd0);

    // Backpressure: the output must stay stable and the input must be stalled.
    axil_write(A_CTRL, 32'd2, 0);
    for (int i = 0; i < N; i++)
      axil_write(coeff_addr(i), (i == 0) ? 32'h7FFF : ((i == 1) ? 32'h4000 : 32'h0), 0);
    axil_write(A_CTRL, 32'd1, 0);
    send(32'h2710_D8F0, 1'b1);
    begin
      int n;
      n = 0;
      while (!m_axis.tvalid && n < LIMIT) begin @(posedge aclk); #1; n++; end
      check("bp_tvalid_wait", 32'(n < LIMIT), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      check("bp_tvalid", 32'(m_axis.tvalid), 32'd1);
      check("bp_tdata", m_axis.tdata, 32'h270F_D8F0);
      check("bp_tlast", 32'(m_axis.tlast), 32'd1);
      check("bp_s_tready", 32'(s_axis.tready), 32'd0);
    end
    recv(d, l, lat);
    check("bp_data", d, 32'h270F_D8F0);

    // CLEAR during the MAC: drop the sample, zero the delay lines, then start again from a clean state.
    send(32'h4E20_4E20, 1'b0);
    repeat (3) begin @(posedge aclk); #1; end
    axil_write(A_CTRL, 32'd3, 0);
    check("clr_tvalid", 32'(m_axis.tvalid), 32'd0);
    check("clr_s_tready", 32'(s_axis.tready), 32'd0);
    repeat (25) begin @(posedge aclk); #1; end
    check("clr_no_output", 32'(m_axis.tvalid), 32'd0);
    axil_write(A_CTRL, 32'd1, 0);
    send(32'h2710_D8F0, 1'b0); recv(d, l, lat); check("post_clr_0", d, 32'h270F_D8F0);
    send(32'h0, 1'b0);         recv(d, l, lat); check("post_clr_1", d, 32'h1388_EC78);
    send(32'h0, 1'b0);         recv(d, l, lat); check("post_clr_2", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
